// File: rtl/rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset sequencer:
//   - state_t     : FSM state encoding (HOLD=0, REL=1, RUN=2, FAULT=3)
//   - DEF_*       : default values for the sequencer parameters
//   - max3        : maximum of three integers
//   - cnt_width   : width of the cycle counters, wide enough that none of the
//                   terminal counts can ever be reached by wrapping
// ---------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        REL   = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int DEF_N_DOM  = 3;
    localparam int DEF_T_HOLD = 3000;
    localparam int DEF_T_GAP  = 100;
    localparam int DEF_T_WDT  = 16000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One spare bit above what the largest terminal count needs.
    function automatic int cnt_width(input int t_hold, input int t_gap, input int t_wdt);
        return $clog2(max3(t_hold, t_gap, t_wdt)) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// ---------------------------------------------------------------------------
// rst_seq_if
// Bundle of the sequencer's functional signals.
//   mr_n      : manual reset request, active-low, asynchronous
//   sence     : supply-good sense, 1 = good, asynchronous
//   wdi       : watchdog kick, rising edge counts, asynchronous
//   wdt_en    : watchdog enable, quasi-static, clk-synchronous
//   rst_out_n : per-domain reset, active-low
//   ready     : high only while all domains run
//   wdo_n     : one-cycle active-low watchdog fault pulse
// Modports:
//   master : the environment (drives the requests, observes the resets)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface rst_seq_if
    import rst_seq_pkg::*;
#(
    parameter int N_DOM = DEF_N_DOM
) ();

    logic             mr_n;
    logic             sence;
    logic             wdi;
    logic             wdt_en;
    logic [N_DOM-1:0] rst_out_n;
    logic             ready;
    logic             wdo_n;

    modport master (
        output mr_n,
        output sence,
        output wdi,
        output wdt_en,
        input  rst_out_n,
        input  ready,
        input  wdo_n
    );

    modport slave (
        input  mr_n,
        input  sence,
        input  wdi,
        input  wdt_en,
        output rst_out_n,
        output ready,
        output wdo_n
    );

endinterface

// File: rtl/rst_seq_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops to 0
//   d     : asynchronous input
//   q     : input resynchronized to clk, two cycles of latency
// ---------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq
// Supply / manual-reset supervisor with staggered release of N_DOM reset
// domains and a watchdog.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset of the sequencer itself
//   bus   : rst_seq_if.slave
//             mr_n, sence, wdi (async inputs, resynchronized here), wdt_en,
//             rst_out_n[N_DOM-1:0], ready, wdo_n (all registered)
// Flow: HOLD waits for T_HOLD stable-good cycles, REL releases one domain
// every T_GAP cycles, RUN supervises the watchdog, FAULT pulses wdo_n and
// drops every domain before returning to HOLD. Losing "good" in any state
// forces HOLD and drops every domain on the edge that observes it.
// ---------------------------------------------------------------------------
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_DOM  = DEF_N_DOM,
    parameter int T_HOLD = DEF_T_HOLD,
    parameter int T_GAP  = DEF_T_GAP,
    parameter int T_WDT  = DEF_T_WDT
) (
    input  logic     clk,
    input  logic     rst_n,
    rst_seq_if.slave bus
);

    localparam int CNT_W = cnt_width(T_HOLD, T_GAP, T_WDT);
    localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(T_WDT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

    // ------------------------------------------------------------------
    // Input synchronization: bit 0 = mr_n, bit 1 = sence, bit 2 = wdi
    // ------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_out;

    assign async_in = {bus.wdi, bus.sence, bus.mr_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        sync2 u_sync2 (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (async_in[gi]),
            .q     (sync_out[gi])
        );
    end

    logic mr_s;
    logic sence_s;
    logic wdi_s;
    logic good;
    logic wdi_rise;

    assign mr_s    = sync_out[0];
    assign sence_s = sync_out[1];
    assign wdi_s   = sync_out[2];
    assign good    = mr_s & sence_s;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [CNT_W-1:0] wdt_reg,     wdt_next;
    logic [IDX_W-1:0] idx_reg,     idx_next;
    logic [N_DOM-1:0] rst_out_reg, rst_out_next;
    logic             ready_reg,   ready_next;
    logic             wdo_n_reg,   wdo_n_next;
    logic             wdi_d_reg;

    assign wdi_rise = wdi_s & ~wdi_d_reg;

    // Domain currently being released, as a one-hot mask.
    logic [N_DOM-1:0] idx_onehot;

    for (genvar gi = 0; gi < N_DOM; gi++) begin : g_onehot
        assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            wdt_reg     <= '0;
            idx_reg     <= '0;
            rst_out_reg <= '0;
            ready_reg   <= 1'b0;
            wdo_n_reg   <= 1'b1;
            wdi_d_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wdt_reg     <= wdt_next;
            idx_reg     <= idx_next;
            rst_out_reg <= rst_out_next;
            ready_reg   <= ready_next;
            wdo_n_reg   <= wdo_n_next;
            wdi_d_reg   <= wdi_s;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        wdt_next   = '0;

        case (state_reg)
            HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = REL;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            REL: begin
                // The last domain is released on the edge that leaves REL.
                if (idx_reg == IDX_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else if (cnt_reg == GAP_LAST) begin
                    idx_next = idx_reg + IDX_W'(1);
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            RUN: begin
                // A kick landing on the terminal count still clears it.
                if (!bus.wdt_en || wdi_rise) begin
                    wdt_next = '0;
                end else if (wdt_reg == WDT_LAST) begin
                    state_next = FAULT;
                end else begin
                    wdt_next = wdt_reg + CNT_W'(1);
                end
            end

            FAULT: begin
                state_next = HOLD;
                cnt_next   = '0;
            end

            default: begin
                state_next = HOLD;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase

        // Loss of supply or a manual reset overrides everything, including
        // a watchdog terminal count on the same cycle.
        if (!good) begin
            state_next = HOLD;
            cnt_next   = '0;
            idx_next   = '0;
            wdt_next   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // Release is driven from the current state, so a domain comes out of
    // reset one edge after the counter that schedules it. Asserting reset
    // is driven from the next state, so it happens on the very edge that
    // decides to leave REL/RUN.
    // ------------------------------------------------------------------
    always_comb begin
        rst_out_next = '0;
        ready_next   = 1'b0;
        wdo_n_next   = 1'b1;

        case (state_reg)
            REL:     rst_out_next = rst_out_reg | idx_onehot;
            RUN:     rst_out_next = '1;
            default: rst_out_next = '0;
        endcase

        if (state_next == HOLD || state_next == FAULT) begin
            rst_out_next = '0;
        end

        ready_next = (state_reg == RUN) && (state_next == RUN);
        wdo_n_next = (state_next != FAULT);
    end

    assign bus.rst_out_n = rst_out_reg;
    assign bus.ready     = ready_reg;
    assign bus.wdo_n     = wdo_n_reg;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq
// Directed stimulus for rst_seq (N_DOM=3, T_HOLD=10, T_GAP=4, T_WDT=20).
// The stimulus process pushes every expected output change, stamped with the
// clock edge on which it must appear, into a queue. A monitor samples the
// outputs on the falling edge and pops one entry per observed change.
// Timing reference: an async input driven just after edge D is seen by the
// FSM at edge D+3; if "good" returns just after edge D it is good from edge
// D+2 (=g), and the domains then release at g+11, g+15, g+19, ready at g+20.
// ---------------------------------------------------------------------------
module tb_rst_seq;

    localparam int N_DOM  = 3;
    localparam int T_HOLD = 10;
    localparam int T_GAP  = 4;
    localparam int T_WDT  = 20;

    typedef struct {
        int         cyc;
        logic [2:0] rst;
        logic       rdy;
        logic       wdo;
        string      tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    exp_t       q[$];
    logic [4:0] prev_out;

    rst_seq_if #(.N_DOM(N_DOM)) bus ();

    rst_seq #(
        .N_DOM  (N_DOM),
        .T_HOLD (T_HOLD),
        .T_GAP  (T_GAP),
        .T_WDT  (T_WDT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got == req) passes++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        if (target > cyc) step(target - cyc);
    endtask

    task automatic push(input int c, input logic [2:0] r, input logic rd, input logic w,
                        input string tag);
        exp_t e;
        e.cyc = c; e.rst = r; e.rdy = rd; e.wdo = w; e.tag = tag;
        q.push_back(e);
    endtask

    // Full release sequence once "good" is established from edge g.
    task automatic push_release(input int g, input string tag);
        push(g + 11, 3'b001, 1'b0, 1'b1, {tag, "_001"});
        push(g + 15, 3'b011, 1'b0, 1'b1, {tag, "_011"});
        push(g + 19, 3'b111, 1'b0, 1'b1, {tag, "_111"});
        push(g + 20, 3'b111, 1'b1, 1'b1, {tag, "_ready"});
    endtask

    task automatic kick();
        bus.wdi = 1'b1;
        step(1);
        bus.wdi = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) step(1);
        chk(name, q.size(), 0);
    endtask

    // Monitor: every change of {rst_out_n, ready, wdo_n} must match the
    // oldest expected entry, both in value and in the edge it appeared on.
    always @(negedge clk) begin
        logic [4:0] cur;
        exp_t       e;
        if (mon_en) begin
            cur = {bus.rst_out_n, bus.ready, bus.wdo_n};
            if (cur !== prev_out) begin
                $display("cyc %0d: rst_out_n=%b ready=%b wdo_n=%b", cyc,
                         bus.rst_out_n, bus.ready, bus.wdo_n);
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_change: got %b required no change from %b (cycle %0d)",
                             cur, prev_out, cyc);
                end else begin
                    e = q.pop_front();
                    chk({e.tag, "_value"}, int'(cur), int'({e.rst, e.rdy, e.wdo}));
                    chk({e.tag, "_cycle"}, cyc, e.cyc);
                end
                prev_out = cur;
            end
        end
    end

    initial begin
        int d, a, f, g, e;

        bus.mr_n   = 1'b1;
        bus.sence  = 1'b1;
        bus.wdi    = 1'b0;
        bus.wdt_en = 1'b1;

        // ---------------- power-up ----------------
        #1 rst_n = 1'b0;
        step(2);
        chk("reset_state", int'({bus.rst_out_n, bus.ready, bus.wdo_n}), int'(5'b000_0_1));
        prev_out = 5'b000_0_1;
        mon_en   = 1'b1;
        step(3);
        rst_n = 1'b1;
        d = cyc;
        push_release(d + 2, "pwr");
        step_to(d + 12);
        chk("no_early_release", int'(bus.rst_out_n), 0);
        drain("drain_pwr", 40);

        // ---------------- kicked RUN, ~200 cycles ----------------
        step_to(d + 22);
        for (int k = 0; k < 14; k++) begin
            kick();
            step(14);
        end
        // The next kick is cleared on the same edge the count would expire.
        step(5);
        a = cyc;
        kick();
        chk("run_steady", int'({bus.rst_out_n, bus.ready, bus.wdo_n}), int'(5'b111_1_1));

        // ---------------- watchdog expiry ----------------
        f = a + 23;
        push(f,      3'b000, 1'b0, 1'b0, "wdt_fault");
        push(f + 1,  3'b000, 1'b0, 1'b1, "wdt_pulse_end");
        push(f + 12, 3'b001, 1'b0, 1'b1, "rerel_001");
        push(f + 16, 3'b011, 1'b0, 1'b1, "rerel_011");

        // ---------------- sence glitch mid-REL ----------------
        // Seen at f+20, the edge that would otherwise release domain 2.
        step_to(f + 17);
        bus.sence = 1'b0;
        d = cyc;
        push(d + 3, 3'b000, 1'b0, 1'b1, "glitch_drop");
        step(1);
        bus.sence = 1'b1;
        push_release(d + 3, "glitch");
        drain("drain_glitch", 60);

        // ---------------- mr_n low on the watchdog terminal edge ----------------
        step_to(d + 23);
        a = cyc;
        kick();
        step_to(a + 20);
        bus.mr_n = 1'b0;
        push(a + 23, 3'b000, 1'b0, 1'b1, "mr_vs_wdt");
        step_to(a + 26);
        chk("mr_wdo_high", int'(bus.wdo_n), 1);
        step_to(a + 30);
        bus.mr_n = 1'b1;
        g = a + 32;
        push_release(g, "mr");
        drain("drain_mr", 60);

        // ---------------- rst_n pulse mid-RUN ----------------
        step_to(g + 25);
        rst_n = 1'b0;
        push(g + 25, 3'b000, 1'b0, 1'b1, "rstn_async");
        #2;
        chk("rstn_immediate", int'({bus.rst_out_n, bus.ready, bus.wdo_n}), int'(5'b000_0_1));
        step(3);
        rst_n = 1'b1;
        e = cyc;
        push_release(e + 2, "rstn");
        drain("drain_rstn", 60);

        // ---------------- watchdog disabled: no kicks, no fault ----------------
        step_to(e + 22);
        bus.wdt_en = 1'b0;
        step(40);
        chk("wdt_disabled", int'({bus.rst_out_n, bus.ready, bus.wdo_n}), int'(5'b111_1_1));
        drain("drain_final", 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter: N_DOM, 3, number of sequenced reset domains (1..8).
REQ-002 Parameter: T_HOLD, 3000, clk cycles supply/manual-reset must be stably good before first release.
REQ-003 Parameter: T_GAP, 100, clk cycles between successive domain releases.
REQ-004 Parameter: T_WDT, 16000, clk cycles without watchdog kick before fault.
REQ-005 Port: clk  input  1  single clock; all logic on rising edge.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: mr_n  input  1  manual reset request, active-low, asynchronous to clk.
REQ-008 Port: sence  input  1  supply-good sense, 1 = good, asynchronous to clk.
REQ-009 Port: wdi  input  1  watchdog kick; a rising edge counts as a kick, asynchronous to clk.
REQ-010 Port: wdt_en  input  1  watchdog enable, quasi-static, synchronous to clk.
REQ-011 Port: rst_out_n  output  N_DOM  per-domain reset, active-low, registered.
REQ-012 Port: ready  output  1  high only in RUN.
REQ-013 Port: wdo_n  output  1  watchdog-fault pulse, active-low, one cycle.

Function
REQ-014 mr_n, sence, wdi SHALL each pass a 2-flop synchronizer (mr_s, sence_s, wdi_s); all latencies below count from the synchronized signal.
REQ-015 FSM SHALL have states HOLD, REL, RUN, FAULT.
REQ-016 good = mr_s & sence_s; in any state, good = 0 SHALL force HOLD next cycle and drive all rst_out_n low, ready low, the same edge.
REQ-017 HOLD: cnt increments while good = 1, clears to 0 when good = 0; at cnt = T_HOLD-1 -> REL, idx = 0, cnt = 0.
REQ-018 REL: rst_out_n[idx] SHALL go high on the REL entry edge for idx 0 and every T_GAP cycles thereafter for idx+1; released bits stay high.
REQ-019 REL: after rst_out_n[N_DOM-1] goes high -> RUN next cycle; ready goes high on that edge.
REQ-020 Total release latency: rst_out_n[0] high T_HOLD+1 cycles after good first samples 1; rst_out_n[i] high i*T_GAP cycles later.
REQ-021 RUN: wdt counter clears on wdi_s rising edge or when wdt_en = 0, else increments; at T_WDT-1 -> FAULT.
REQ-022 FAULT (one cycle): wdo_n low, all rst_out_n low, ready low; -> HOLD with cnt = 0.
REQ-023 Kick and wdt terminal count in same cycle: kick wins, no fault.
REQ-024 good = 0 and wdt terminal count in same cycle: HOLD wins, wdo_n stays high.
REQ-025 good glitch low during REL SHALL re-assert all domains and restart the full T_HOLD count.
REQ-026 Counters SHALL be sized to clog2(max(T_HOLD, T_GAP, T_WDT))+1 bits and never wrap.

Reset
REQ-027 rst_n low SHALL asynchronously set: state = HOLD, cnt = 0, wdt = 0, idx = 0, synchronizer flops = 0, rst_out_n = 0, ready = 0, wdo_n = 1.
REQ-028 rst_n release SHALL be followed by normal HOLD counting; no output change before T_HOLD+3 cycles.

Structure
REQ-029 Package rst_seq_pkg SHALL hold the state encoding constants (HOLD = 0, REL = 1, RUN = 2, FAULT = 3) and parameter defaults.
REQ-030 One sub-module, sync2 (2-flop synchronizer, async active-low reset to 0), SHALL be instanced three times.

Verification
REQ-031 Bench params N_DOM = 3, T_HOLD = 10, T_GAP = 4, T_WDT = 20, wdt_en = 1.
REQ-032 Power-up: rst_n low 5 cycles, sence = mr_n = 1 -> rst_out_n = 001, 011, 111 at cycles 13, 17, 21 after rst_n rise; ready at 22.
REQ-033 Kick every 15 cycles in RUN for 200 cycles -> wdo_n never low, rst_out_n stays 111.
REQ-034 Stop kicking -> wdo_n low one cycle 20 cycles after last synchronized kick, rst_out_n = 000, full re-release follows.
REQ-035 sence low 1 cycle mid-REL (after 011) -> rst_out_n = 000 within 3 cycles, re-release restarts with full T_HOLD = 10.
REQ-036 mr_n low while wdt terminal count coincides -> HOLD, wdo_n stays 1; rst_n pulse mid-RUN -> all outputs at reset values immediately.
